iob_vexriscv_bus_arbiter: RTL and testbench
===========================================

Name: iob_vexriscv_bus_arbiter

Overview:
- Shares one IOb native memory port between the CPU instruction bus (requester 0) and data bus (requester 1).
- Sits between the VexRiscv wrapper and the SoC memory/interconnect.
- Arbitrates round-robin and locks the grant until the downstream accepts the request.
- Tracks outstanding reads in an ID FIFO so each rvalid/rdata is routed to the requester that issued it.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8
- OUTST_W, 2, log2 of maximum outstanding reads (depth 2**OUTST_W = 4)

Ports:
- clk_i  in  1  clock
- arst_n_i  in  1  asynchronous active-low reset
- cke_i  in  1  clock enable; when low, all state holds
- r0_avalid_i / r1_avalid_i  in  1  requester request valid
- r0_addr_i / r1_addr_i  in  ADDR_W  request address
- r0_wdata_i / r1_wdata_i  in  DATA_W  write data
- r0_wstrb_i / r1_wstrb_i  in  DATA_W/8  byte strobe; 0 means read
- r0_ready_o / r1_ready_o  out  1  request accepted this cycle
- r0_rvalid_o / r1_rvalid_o  out  1  read data valid
- r0_rdata_o / r1_rdata_o  out  DATA_W  read data (the shared m_rdata_i is driven to both)
- m_avalid_o  out  1  memory request valid
- m_addr_o  out  ADDR_W  memory address
- m_wdata_o  out  DATA_W  memory write data
- m_wstrb_o  out  DATA_W/8  memory strobe
- m_ready_i  in  1  memory accepts request
- m_rvalid_i  in  1  memory read response valid
- m_rdata_i  in  DATA_W  memory read data
- outst_o  out  OUTST_W+1  current outstanding-read count
- err_o  out  1  sticky error: m_rvalid_i received with no read outstanding

Behaviour:
- Reset (arst_n_i=0, asynchronous): lock=0, last_grant=1 (so requester 0 wins first), FIFO empty, outst_o=0, err_o=0.
  - All *_o request/response strobes are 0 while in reset.
- Eligibility:
  - Requester k is eligible when rk_avalid_i=1.
  - If rk_wstrb_i==0 (read), it is eligible only when the ID FIFO is not full.
  - Writes are always eligible.
- Arbitration (combinational, zero-latency):
  - lock=0: grant goes to the single eligible requester.
  - If both are eligible, grant goes to the one not equal to last_grant.
  - lock=1: grant = locked requester regardless of the other.
- Mux: m_avalid_o = granted requester's avalid, gated by eligibility.
  - m_addr_o, m_wdata_o and m_wstrb_o come from the granted requester.
  - With no grant, all are 0.
- Accept: rk_ready_o = m_ready_i & m_avalid_o & (grant==k). The other requester's ready is 0.
- Lock: set when m_avalid_o=1 & m_ready_i=0.
  - Holds the grant so the pending request stays stable.
  - Cleared on the accept cycle.
- last_grant updates to k on each accepted request.
- ID FIFO:
  - On an accepted read, push k.
  - On m_rvalid_i, pop the head and assert r<head>_rvalid_o in the same cycle (combinational).
  - Push and pop may occur in the same cycle: count is unchanged and ordering is preserved.
  - Pointers wrap modulo 2**OUTST_W; the count saturates neither way.
  - Full blocks new reads only.
- Writes generate no response and no FIFO entry.
- Read latency: arbiter adds 0 cycles on request and response paths.
- m_rvalid_i with FIFO empty: no rvalid_o is asserted, err_o is set to 1 and stays set until reset.
- Full FIFO with a pending locked read: lock cannot occur, because an ineligible read never drives m_avalid_o.
- Reset mid-transaction: all outstanding IDs are discarded.
  - Responses arriving after reset set err_o.

Test Plan:
- Only r0 reads addr 0x100, m_ready_i=1, m_rvalid_i 2 cycles later with 0xDEADBEEF:
  - r0_ready_o=1 in the request cycle.
  - 2 cycles later r0_rvalid_o=1 with r0_rdata_o=0xDEADBEEF; r1_rvalid_o=0.
- r0 and r1 both read continuously, m_ready_i=1 with 1-cycle response:
  - Grants alternate 0,1,0,1.
  - Each rvalid is routed to the matching requester; outst_o never exceeds 2.
- r1 writes 0x0000_00AA with wstrb 4'b0001 while m_ready_i=0 for 3 cycles, r0 requesting:
  - m_avalid_o, m_addr_o and m_wdata_o stay on r1 for all 3 cycles.
  - r1_ready_o=1 on cycle 4; r0 is granted next; no FIFO push occurs.
- Issue 4 reads from r1 without responses:
  - outst_o=4 and a 5th read is blocked (m_avalid_o=0).
  - A concurrent r0 write is still accepted.
  - After one m_rvalid_i, the blocked read is accepted on the next cycle.
- Push and pop in the same cycle with outst_o=2:
  - outst_o stays 2 and response order matches request order across pointer wrap.
- Spurious m_rvalid_i after reset:
  - err_o=1 and both rvalid_o stay 0.
  - err_o clears only on arst_n_i=0.

Source files
------------

// File: rtl/iob_vexriscv_bus_arbiter_if.sv
// IOb native port bundle: request channel (avalid/addr/wdata/wstrb/ready)
// and read response channel (rvalid/rdata).
interface iob_vexriscv_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  avalid;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  ready;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output avalid, addr, wdata, wstrb,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  avalid, addr, wdata, wstrb,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/iob_vexriscv_bus_arbiter.sv
// Round-robin arbiter sharing one IOb port between the VexRiscv instruction
// (r0) and data (r1) buses; read IDs are queued so responses route back.
module iob_vexriscv_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int OUTST_W = 2
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    input  logic                  cke_i,
    iob_vexriscv_bus_arbiter_if.slave  r0,
    iob_vexriscv_bus_arbiter_if.slave  r1,
    iob_vexriscv_bus_arbiter_if.master m,
    output logic [OUTST_W:0]      outst_o,
    output logic                  err_o
);

    localparam int DEPTH  = 2 ** OUTST_W;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic {
        ST_FREE,
        ST_LOCKED
    } lock_state_e;

    lock_state_e          state_q, state_d;
    logic                 lock_id_q, lock_id_d;
    logic                 last_q, last_d;
    logic [OUTST_W-1:0]   wptr_q, wptr_d;
    logic [OUTST_W-1:0]   rptr_q, rptr_d;
    logic [OUTST_W:0]     cnt_q, cnt_d;
    logic [DEPTH-1:0]     id_q, id_d;
    logic                 err_q, err_d;

    logic                 full, empty;
    logic                 elig0, elig1;
    logic                 gnt_vld, gnt_id;
    logic [ADDR_W-1:0]    gnt_addr;
    logic [DATA_W-1:0]    gnt_wdata;
    logic [STRB_W-1:0]    gnt_wstrb;
    logic                 accept, push, pop, head;

    assign full  = (cnt_q == (OUTST_W+1)'(DEPTH));
    assign empty = (cnt_q == '0);

    // A read can only compete while there is room to remember its ID.
    assign elig0 = r0.avalid & ((|r0.wstrb) | ~full);
    assign elig1 = r1.avalid & ((|r1.wstrb) | ~full);

    always_comb begin
        gnt_id  = 1'b0;
        gnt_vld = 1'b0;
        if (state_q == ST_LOCKED) begin
            gnt_id  = lock_id_q;
            gnt_vld = lock_id_q ? elig1 : elig0;
        end else if (elig0 && elig1) begin
            gnt_id  = ~last_q;
            gnt_vld = 1'b1;
        end else if (elig0) begin
            gnt_id  = 1'b0;
            gnt_vld = 1'b1;
        end else if (elig1) begin
            gnt_id  = 1'b1;
            gnt_vld = 1'b1;
        end
        gnt_vld = gnt_vld & arst_n_i;
    end

    always_comb begin
        gnt_addr  = '0;
        gnt_wdata = '0;
        gnt_wstrb = '0;
        if (gnt_vld) begin
            if (gnt_id) begin
                gnt_addr  = r1.addr;
                gnt_wdata = r1.wdata;
                gnt_wstrb = r1.wstrb;
            end else begin
                gnt_addr  = r0.addr;
                gnt_wdata = r0.wdata;
                gnt_wstrb = r0.wstrb;
            end
        end
    end

    assign m.avalid = gnt_vld;
    assign m.addr   = gnt_addr;
    assign m.wdata  = gnt_wdata;
    assign m.wstrb  = gnt_wstrb;

    assign accept   = gnt_vld & m.ready;
    assign push     = accept & ~(|gnt_wstrb);
    assign r0.ready = accept & ~gnt_id;
    assign r1.ready = accept & gnt_id;

    assign head      = id_q[rptr_q];
    assign pop       = m.rvalid & ~empty;
    assign r0.rvalid = pop & ~head;
    assign r1.rvalid = pop & head;
    assign r0.rdata  = m.rdata;
    assign r1.rdata  = m.rdata;

    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        last_d    = last_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        cnt_d     = cnt_q;
        id_d      = id_q;
        err_d     = err_q;
        if (cke_i) begin
            // Stalled request pins the grant; any other cycle releases it.
            if (gnt_vld && !m.ready) begin
                state_d   = ST_LOCKED;
                lock_id_d = gnt_id;
            end else begin
                state_d   = ST_FREE;
            end
            if (accept) begin
                last_d = gnt_id;
            end
            if (push) begin
                id_d[wptr_q] = gnt_id;
                wptr_d       = wptr_q + OUTST_W'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + OUTST_W'(1);
            end
            if (push && !pop) begin
                cnt_d = cnt_q + (OUTST_W+1)'(1);
            end else if (pop && !push) begin
                cnt_d = cnt_q - (OUTST_W+1)'(1);
            end
            if (m.rvalid && empty) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q   <= ST_FREE;
            lock_id_q <= 1'b0;
            last_q    <= 1'b1;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            id_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            last_q    <= last_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            id_q      <= id_d;
            err_q     <= err_d;
        end
    end

    assign outst_o = cnt_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_iob_vexriscv_bus_arbiter.sv
// Directed bench for iob_vexriscv_bus_arbiter: a queue-based reference model
// is compared every cycle, plus hand-computed literal checks per scenario.
module tb_iob_vexriscv_bus_arbiter;

    logic       clk;
    logic       rst_n;
    logic       cke;
    logic [2:0] outst;
    logic       err;

    iob_vexriscv_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) r0_if ();
    iob_vexriscv_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) r1_if ();
    iob_vexriscv_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m_if ();

    iob_vexriscv_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .OUTST_W(2)) dut (
        .clk_i    (clk),
        .arst_n_i (rst_n),
        .cke_i    (cke),
        .r0       (r0_if),
        .r1       (r1_if),
        .m        (m_if),
        .outst_o  (outst),
        .err_o    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    int   q[$];
    int   last_g;
    bit   locked;
    int   lock_g;
    bit   err_m;
    // expectations for the current cycle
    bit          ev;
    int          eg;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wstrb;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        last_g = 1;
        locked = 1'b0;
        lock_g = 0;
        err_m  = 1'b0;
    endtask

    task automatic drive(input int k, input bit av, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws);
        if (k == 0) begin
            r0_if.avalid = av; r0_if.addr = a; r0_if.wdata = wd; r0_if.wstrb = ws;
        end else begin
            r1_if.avalid = av; r1_if.addr = a; r1_if.wdata = wd; r1_if.wstrb = ws;
        end
    endtask

    task automatic mem(input bit rdy, input bit rv, input logic [31:0] rd);
        m_if.ready = rdy; m_if.rvalid = rv; m_if.rdata = rd;
    endtask

    // Settle inputs, derive the expected outputs from the model and compare.
    task automatic eval();
        bit e0, e1, full, rv0, rv1;
        #1;
        full = (q.size() >= 4);
        e0 = r0_if.avalid && (r0_if.wstrb != 4'h0 || !full);
        e1 = r1_if.avalid && (r1_if.wstrb != 4'h0 || !full);
        ev = 1'b0; eg = 0;
        if (!rst_n) begin
            ev = 1'b0;
        end else if (locked) begin
            eg = lock_g; ev = (eg == 0) ? e0 : e1;
        end else if (e0 && e1) begin
            eg = 1 - last_g; ev = 1'b1;
        end else if (e0) begin
            eg = 0; ev = 1'b1;
        end else if (e1) begin
            eg = 1; ev = 1'b1;
        end
        e_addr = '0; e_wdata = '0; e_wstrb = '0;
        if (ev) begin
            e_addr  = (eg == 0) ? r0_if.addr  : r1_if.addr;
            e_wdata = (eg == 0) ? r0_if.wdata : r1_if.wdata;
            e_wstrb = (eg == 0) ? r0_if.wstrb : r1_if.wstrb;
        end
        rv0 = m_if.rvalid && q.size() > 0 && q[0] == 0;
        rv1 = m_if.rvalid && q.size() > 0 && q[0] == 1;
        chk("m_avalid", 32'(m_if.avalid), 32'(ev));
        chk("m_addr",   m_if.addr, e_addr);
        chk("m_wdata",  m_if.wdata, e_wdata);
        chk("m_wstrb",  32'(m_if.wstrb), 32'(e_wstrb));
        chk("r0_ready", 32'(r0_if.ready), 32'(ev && m_if.ready && eg == 0));
        chk("r1_ready", 32'(r1_if.ready), 32'(ev && m_if.ready && eg == 1));
        chk("r0_rvalid", 32'(r0_if.rvalid), 32'(rv0));
        chk("r1_rvalid", 32'(r1_if.rvalid), 32'(rv1));
        chk("r0_rdata", r0_if.rdata, m_if.rdata);
        chk("r1_rdata", r1_if.rdata, m_if.rdata);
        chk("outst", 32'(outst), q.size());
        chk("err", 32'(err), 32'(err_m));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (cke) begin
            if (m_if.rvalid) begin
                if (q.size() > 0) void'(q.pop_front());
                else err_m = 1'b1;
            end
            if (ev && m_if.ready) begin
                if (e_wstrb == 4'h0) q.push_back(eg);
                last_g = eg;
            end
            locked = ev && !m_if.ready;
            if (locked) lock_g = eg;
        end
        #1;
    endtask

    task automatic step();
        eval();
        tick();
    endtask

    task automatic idle_all();
        drive(0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0);
        mem(1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        cke   = 1'b1;
        idle_all();
        model_reset();
        @(posedge clk); #1;

        // reset state: a requester held high must not reach the memory port
        drive(0, 1'b1, 32'h100, '0, 4'h0);
        mem(1'b1, 1'b0, '0);
        eval();
        chk("rst_m_avalid", 32'(m_if.avalid), 32'd0);
        chk("rst_outst", 32'(outst), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        tick();
        idle_all();
        do_reset();

        // single r0 read, response two cycles later
        drive(0, 1'b1, 32'h100, '0, 4'h0);
        mem(1'b1, 1'b0, '0);
        eval();
        chk("s1_r0_ready", 32'(r0_if.ready), 32'd1);
        chk("s1_addr", m_if.addr, 32'h100);
        tick();
        drive(0, 1'b0, '0, '0, '0);
        step();
        mem(1'b1, 1'b1, 32'hDEADBEEF);
        eval();
        chk("s1_r0_rvalid", 32'(r0_if.rvalid), 32'd1);
        chk("s1_r0_rdata", r0_if.rdata, 32'hDEADBEEF);
        chk("s1_r1_rvalid", 32'(r1_if.rvalid), 32'd0);
        tick();
        idle_all();
        do_reset();

        // both read continuously, 1-cycle response: grants alternate
        for (int i = 0; i < 8; i++) begin
            drive(0, 1'b1, 32'h1000 + i, '0, 4'h0);
            drive(1, 1'b1, 32'h2000 + i, '0, 4'h0);
            mem(1'b1, i > 0, 32'h100 + i);
            eval();
            chk("s2_r0_gnt", 32'(r0_if.ready), 32'(i % 2 == 0));
            chk("s2_r1_gnt", 32'(r1_if.ready), 32'(i % 2 == 1));
            chk("s2_r0_rvalid", 32'(r0_if.rvalid), 32'(i > 0 && (i - 1) % 2 == 0));
            chk("s2_outst_le2", 32'(outst <= 3'd2), 32'd1);
            tick();
        end
        drive(0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0);
        mem(1'b0, 1'b1, 32'h1FF);
        step();
        idle_all();
        do_reset();

        // r1 write stalled 3 cycles while r0 competes
        for (int c = 1; c <= 4; c++) begin
            drive(1, 1'b1, 32'h200, 32'h0000_00AA, 4'b0001);
            drive(0, c >= 2, 32'h300, '0, 4'h0);
            mem(c == 4, 1'b0, '0);
            eval();
            chk("s3_avalid", 32'(m_if.avalid), 32'd1);
            chk("s3_addr", m_if.addr, 32'h200);
            chk("s3_wdata", m_if.wdata, 32'h0000_00AA);
            chk("s3_r1_ready", 32'(r1_if.ready), 32'(c == 4));
            chk("s3_r0_ready", 32'(r0_if.ready), 32'd0);
            tick();
        end
        drive(1, 1'b0, '0, '0, '0);
        eval();
        chk("s3_r0_next", 32'(r0_if.ready), 32'd1);
        chk("s3_no_push", 32'(outst), 32'd0);
        tick();
        drive(0, 1'b0, '0, '0, '0);
        mem(1'b0, 1'b1, 32'h33);
        step();
        idle_all();
        do_reset();

        // fill the ID FIFO with r1 reads; r0 write still passes
        for (int i = 0; i < 4; i++) begin
            drive(1, 1'b1, 32'h400 + 4 * i, '0, 4'h0);
            mem(1'b1, 1'b0, '0);
            step();
        end
        drive(1, 1'b1, 32'h410, '0, 4'h0);
        drive(0, 1'b1, 32'h500, 32'h55, 4'hF);
        eval();
        chk("s4_outst4", 32'(outst), 32'd4);
        chk("s4_r0_wr", 32'(r0_if.ready), 32'd1);
        chk("s4_r1_blk", 32'(r1_if.ready), 32'd0);
        tick();
        drive(0, 1'b0, '0, '0, '0);
        eval();
        chk("s4_blocked", 32'(m_if.avalid), 32'd0);
        tick();
        mem(1'b1, 1'b1, 32'h11);
        eval();
        chk("s4_r1_rvalid", 32'(r1_if.rvalid), 32'd1);
        chk("s4_still_blk", 32'(m_if.avalid), 32'd0);
        tick();
        mem(1'b1, 1'b0, '0);
        eval();
        chk("s4_unblock", 32'(r1_if.ready), 32'd1);
        chk("s4_outst3", 32'(outst), 32'd3);
        tick();
        drive(1, 1'b0, '0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            mem(1'b0, 1'b1, 32'h20 + i);
            step();
        end
        mem(1'b0, 1'b0, '0);
        step();

        // push+pop together at depth 2, across pointer wrap
        for (int i = 0; i < 8; i++) begin
            drive(0, 1'b1, 32'h600 + i, '0, 4'h0);
            drive(1, 1'b1, 32'h700 + i, '0, 4'h0);
            mem(1'b1, i >= 2, 32'h50 + i);
            eval();
            if (i >= 2) begin
                chk("s5_outst2", 32'(outst), 32'd2);
                chk("s5_order", 32'(r0_if.rvalid), 32'(i % 2 == 0));
            end
            tick();
        end
        drive(0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0);
        for (int i = 0; i < 2; i++) begin
            mem(1'b0, 1'b1, 32'h90 + i);
            step();
        end
        chk("s5_drained", 32'(outst), 32'd0);
        idle_all();

        // reset with a read outstanding, then a stray response
        drive(0, 1'b1, 32'h800, '0, 4'h0);
        mem(1'b1, 1'b0, '0);
        step();
        idle_all();
        chk("s6_outst1", 32'(outst), 32'd1);
        rst_n = 1'b0;
        model_reset();
        eval();
        chk("s6_rst_outst", 32'(outst), 32'd0);
        tick();
        rst_n = 1'b1;
        mem(1'b0, 1'b1, 32'hBAD);
        eval();
        chk("s6_r0_rvalid", 32'(r0_if.rvalid), 32'd0);
        chk("s6_r1_rvalid", 32'(r1_if.rvalid), 32'd0);
        tick();
        mem(1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            eval();
            chk("s6_err_sticky", 32'(err), 32'd1);
            tick();
        end
        rst_n = 1'b0;
        model_reset();
        eval();
        chk("s6_err_clr", 32'(err), 32'd0);
        tick();
        rst_n = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
